// File: rtl/video_pkg.sv
// Shared video definitions: active-area defaults, pixel word layout and the
// fetch FSM encoding. Also used by the timing generator.
package video_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned V_ACTIVE_DEF = 480;

  // Pixel word as stored in the FIFO: {r[2:0], g[2:0], b[2:0]}
  localparam int unsigned PIX_W = 9;
  localparam int unsigned R_MSB = 8;
  localparam int unsigned R_LSB = 6;
  localparam int unsigned G_MSB = 5;
  localparam int unsigned G_LSB = 3;
  localparam int unsigned B_MSB = 2;
  localparam int unsigned B_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/video_pixel_fifo.sv
// First-word-fall-through pixel FIFO with occupancy count and synchronous
// flush. The head entry is presented combinationally; zero when empty.
module video_pixel_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 9
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign empty   = (count_q == '0);
  assign full    = (count_q == DEPTH_C);
  assign count   = count_q;
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointer and count update; a pop on an empty FIFO is ignored.
  always_comb begin
    do_rd    = rd_en & ~empty;
    do_wr    = wr_en & (~full | do_rd);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
      if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
      case ({do_wr, do_rd})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/video_pixel_fetch.sv
// Fetches one frame of pixel words from sequential memory addresses into a
// small FWFT FIFO and presents the head pixel as r/g/b to the consumer.
module video_pixel_fetch
  import video_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned ADDR_W     = 19,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_rd,
  output logic [2:0]        r,
  output logic [2:0]        g,
  output logic [2:0]        b,
  output logic              pix_valid,
  output logic              underrun,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [15:0]       mem_data
);

  localparam int unsigned TOTAL = H_ACTIVE * V_ACTIVE;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam int unsigned FC_W  = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  LAST     = CNT_W'(TOTAL - 1);
  localparam logic [FC_W-1:0]   DEPTH_M1 = FC_W'(FIFO_DEPTH - 1);

  fetch_state_e      state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [CNT_W-1:0]  fetch_cnt_q, fetch_cnt_d;
  logic              drop_q, drop_d;
  logic              underrun_q, underrun_d;

  logic              fifo_flush, fifo_wr, fifo_rd;
  logic              fifo_empty, fifo_full;
  logic [FC_W-1:0]   fifo_count;
  logic [PIX_W-1:0]  head;
  logic              ack;
  logic              unused_hi;

  assign ack       = mem_req_q & mem_ack;
  assign unused_hi = ^mem_data[15:9];

  video_pixel_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PIX_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .flush   (fifo_flush),
    .wr_en   (fifo_wr),
    .wr_data (mem_data[PIX_W-1:0]),
    .rd_en   (fifo_rd),
    .rd_data (head),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

  assign r         = head[R_MSB:R_LSB];
  assign g         = head[G_MSB:G_LSB];
  assign b         = head[B_MSB:B_LSB];
  assign pix_valid = ~fifo_empty;
  assign underrun  = underrun_q;
  assign mem_req   = mem_req_q;
  assign mem_addr  = mem_addr_q;

  // Fetch sequencing: request issue, ack handling, restart and drop tracking.
  // A request still in flight at frame_start keeps its address on the bus
  // until acked; the reload to BASE happens on that discarded ack instead.
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    fetch_cnt_d = fetch_cnt_q;
    drop_d      = drop_q;
    underrun_d  = underrun_q;
    fifo_flush  = 1'b0;
    fifo_wr     = 1'b0;
    fifo_rd     = 1'b0;
    if (frame_start) begin
      fifo_flush  = 1'b1;
      underrun_d  = 1'b0;
      fetch_cnt_d = '0;
      state_d     = ST_FETCH;
      if (mem_req_q && !mem_ack) begin
        drop_d = 1'b1;
      end else begin
        mem_req_d  = 1'b0;
        drop_d     = 1'b0;
        mem_addr_d = BASE;
      end
    end else begin
      if (pix_rd) begin
        if (fifo_empty) underrun_d = 1'b1;
        else            fifo_rd    = 1'b1;
      end
      if (ack) begin
        mem_req_d = 1'b0;
        if (drop_q) begin
          drop_d     = 1'b0;
          mem_addr_d = BASE;
        end else begin
          fifo_wr     = 1'b1;
          mem_addr_d  = mem_addr_q + ADDR_W'(1);
          fetch_cnt_d = fetch_cnt_q + CNT_W'(1);
          if (fetch_cnt_q == LAST) begin
            state_d = ST_DONE;
          end else if (state_q == ST_FETCH && (fifo_rd || fifo_count < DEPTH_M1)) begin
            mem_req_d = 1'b1;
          end
        end
      end else if (!mem_req_q && state_q == ST_FETCH && !fifo_full) begin
        mem_req_d = 1'b1;
      end
    end
  end

  // FSM and fetch state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= BASE;
      fetch_cnt_q <= '0;
      drop_q      <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      fetch_cnt_q <= fetch_cnt_d;
      drop_q      <= drop_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_video_pixel_fetch.sv
// Directed bench for video_pixel_fetch: a vector table of frame scenarios
// plus hand sequences for mid-fetch restart and asynchronous reset.
module tb_video_pixel_fetch;
  import video_pkg::*;

  localparam int unsigned AW   = 19;
  localparam int          BASE = 32'h100;

  logic          clk;
  logic          rst;
  logic          frame_start;
  logic          pix_rd;
  logic [2:0]    r, g, b;
  logic          pix_valid;
  logic          underrun;
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic          mem_ack;
  logic [15:0]   mem_data;

  int total = 0;
  int bad   = 0;
  int wait_n = 0;
  int req_log[$];
  int pop_log[$];
  int empty_cycles = 0;
  int empty_rgb_bad = 0;
  int stab_bad = 0;

  typedef struct {
    string        name;
    int           wait_n;
    int           rd_period;
    int           rd_start;
    int           rd_max;
    int           cycles;
    int           exp_reqs;
    int           exp_pops;
    int           exp_underrun;
    int           exp_valid;
    int           exp_rgb;
    fetch_state_e exp_state;
  } vec_t;

  vec_t vecs[4];

  video_pixel_fetch #(
    .H_ACTIVE   (4),
    .V_ACTIVE   (2),
    .ADDR_W     (AW),
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_rd      (pix_rd),
    .r           (r),
    .g           (g),
    .b           (b),
    .pix_valid   (pix_valid),
    .underrun    (underrun),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_data    (mem_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Memory: ack arrives wait_n cycles after the request's first full cycle;
  // data is the low 9 address bits.
  initial begin
    int seen;
    seen = 0;
    mem_ack = 1'b0;
    mem_data = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst || !mem_req) begin
        mem_ack = 1'b0;
        seen = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
        seen = 1;
      end else if (seen == wait_n + 1) begin
        mem_ack = 1'b1;
        mem_data = {7'd0, mem_addr[8:0]};
        seen = 0;
      end else begin
        seen++;
      end
    end
  end

  // Monitor: ack/pop logs, zero pixel while empty, request stability.
  initial begin
    logic          prev_req;
    logic          prev_ack;
    logic [AW-1:0] prev_addr;
    prev_req = 1'b0;
    prev_ack = 1'b0;
    prev_addr = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_req = 1'b0;
      end else begin
        if (mem_req && mem_ack && !frame_start) req_log.push_back(int'(mem_addr));
        if (pix_rd && pix_valid && !frame_start) pop_log.push_back(int'({r, g, b}));
        if (!pix_valid) begin
          empty_cycles++;
          if ({r, g, b} != 9'd0) empty_rgb_bad++;
        end
        if (prev_req && !prev_ack && (!mem_req || mem_addr != prev_addr)) stab_bad++;
        prev_req = mem_req;
        prev_ack = mem_ack;
        prev_addr = mem_addr;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic pulse_frame_start();
    frame_start = 1'b1;
    req_log.delete();
    pop_log.delete();
    step();
    frame_start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int  k;
    int  nrd;
    bit  started;
    wait_n = v.wait_n;
    pulse_frame_start();
    check({v.name, " underrun clear"}, int'(underrun), 0);
    check({v.name, " flushed"}, int'(pix_valid), 0);
    empty_rgb_bad = 0;
    empty_cycles = 0;
    k = 0;
    nrd = 0;
    started = 1'b0;
    for (int c = 0; c < v.cycles; c++) begin
      if (v.rd_period == 0) begin
        pix_rd = 1'b0;
      end else begin
        if (c >= v.rd_start) started = 1'b1;
        pix_rd = started && (k % v.rd_period == 0) && (v.rd_max == 0 || nrd < v.rd_max);
        if (pix_rd) nrd++;
        if (started) k++;
      end
      step();
    end
    pix_rd = 1'b0;
    check({v.name, " reqs"}, req_log.size(), v.exp_reqs);
    for (int i = 0; i < req_log.size() && i < v.exp_reqs; i++)
      check($sformatf("%s req%0d addr", v.name, i), req_log[i], BASE + i);
    check({v.name, " pops"}, pop_log.size(), v.exp_pops);
    for (int i = 0; i < pop_log.size() && i < v.exp_pops; i++)
      check($sformatf("%s pop%0d rgb", v.name, i), pop_log[i], (BASE + i) & 32'h1ff);
    check({v.name, " underrun"}, int'(underrun), v.exp_underrun);
    check({v.name, " pix_valid"}, int'(pix_valid), v.exp_valid);
    check({v.name, " head rgb"}, int'({r, g, b}), v.exp_rgb);
    check({v.name, " mem_req idle"}, int'(mem_req), 0);
    check({v.name, " state"}, int'(dut.state_q), int'(v.exp_state));
    if (empty_cycles > 0) check({v.name, " rgb zero when empty"}, empty_rgb_bad, 0);
  endtask

  initial begin
    bit found;

    vecs[0] = '{"prefetch", 0, 0, 0, 0, 30, 4, 0, 0, 1, 256, ST_FETCH};
    vecs[1] = '{"frame_w2", 2, 3, 20, 8, 80, 8, 8, 0, 0, 0, ST_DONE};
    vecs[2] = '{"underrun", 5, 1, 0, 0, 90, 8, 8, 1, 0, 0, ST_DONE};
    vecs[3] = '{"frame_w0", 0, 2, 10, 8, 50, 8, 8, 0, 0, 0, ST_DONE};

    rst = 1'b0;
    frame_start = 1'b0;
    pix_rd = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset mem_req", int'(mem_req), 0);
    check("reset mem_addr", int'(mem_addr), BASE);
    check("reset pix_valid", int'(pix_valid), 0);
    check("reset underrun", int'(underrun), 0);
    rst = 1'b1;

    // Idle without frame_start: nothing moves.
    for (int i = 0; i < 20; i++) begin
      step();
      check($sformatf("idle%0d mem_req", i), int'(mem_req), 0);
      check($sformatf("idle%0d pix_valid", i), int'(pix_valid), 0);
      check($sformatf("idle%0d rgb", i), int'({r, g, b}), 0);
      check($sformatf("idle%0d mem_addr", i), int'(mem_addr), BASE);
    end
    check("idle state", int'(dut.state_q), int'(ST_IDLE));

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // Restart while the request for 0x102 is pending; its ack is discarded.
    wait_n = 2;
    pulse_frame_start();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (mem_req && mem_addr == AW'(BASE + 2)) found = 1'b1;
      else step();
    end
    check("restart req 0x102 seen", int'(found), 1);
    pulse_frame_start();
    check("restart flushed", int'(pix_valid), 0);
    check("restart req held", int'(mem_req), 1);
    check("restart addr held", int'(mem_addr), BASE + 2);
    step();
    step();
    step();
    check("restart no write", int'(pix_valid), 0);
    check("restart addr reload", int'(mem_addr), BASE);
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      if (mem_req) found = 1'b1;
      else step();
    end
    check("restart new req seen", int'(found), 1);
    check("restart new req addr", int'(mem_addr), BASE);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pix_valid) found = 1'b1;
      else step();
    end
    check("restart first word seen", int'(found), 1);
    check("restart first word rgb", int'({r, g, b}), BASE & 32'h1ff);

    // Async reset mid-frame with a live request, data and underrun.
    wait_n = 1;
    pulse_frame_start();
    pix_rd = 1'b1;
    step();
    pix_rd = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (pix_valid && mem_req) found = 1'b1;
      else step();
    end
    check("areset pre valid+req", int'(found), 1);
    check("areset pre underrun", int'(underrun), 1);
    #2 rst = 1'b0;
    #1;
    check("areset mem_req", int'(mem_req), 0);
    check("areset pix_valid", int'(pix_valid), 0);
    check("areset underrun", int'(underrun), 0);
    check("areset rgb", int'({r, g, b}), 0);
    check("areset mem_addr", int'(mem_addr), BASE);
    check("areset state", int'(dut.state_q), int'(ST_IDLE));
    step();
    rst = 1'b1;
    repeat (5) step();
    check("post-reset idle mem_req", int'(mem_req), 0);
    check("req stable until ack", stab_bad, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/video_pixel_fetch.md
Name: video_pixel_fetch

Overview:
- Upstream feeder for the video timing generator: fetches pixel words from video memory and supplies 3-bit r/g/b per pixel on demand.
- Runs sequential addresses from BASE_ADDR through one frame.
- Hides memory latency behind a small first-word-fall-through FIFO.
- Consumer pops one pixel per active-area pixel clock.

Parameters:
- H_ACTIVE, 640: active pixels per line.
- V_ACTIVE, 480: active lines per frame.
- ADDR_W, 19: memory address width; must hold BASE_ADDR + H_ACTIVE*V_ACTIVE - 1.
- BASE_ADDR, 0: address of the first pixel of the frame.
- FIFO_DEPTH, 16: pixel FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset, asynchronous, active-low.
- frame_start  in  1  one-cycle pulse before the first active pixel of a frame; restarts fetch.
- pix_rd  in  1  consumer pops the current head pixel this cycle.
- r  out  3  head pixel red, mem_data[8:6].
- g  out  3  head pixel green, mem_data[5:3].
- b  out  3  head pixel blue, mem_data[2:0].
- pix_valid  out  1  FIFO non-empty; r/g/b are meaningful.
- underrun  out  1  sticky: pix_rd seen while empty in this frame.
- mem_req  out  1  read request; held until acknowledged.
- mem_addr  out  ADDR_W  read address; stable while mem_req is high.
- mem_ack  in  1  one-cycle acknowledge; mem_data valid in the same cycle.
- mem_data  in  16  read word; bits 15:9 ignored.

Behaviour:
- Reset (rst low, async):
  - mem_req=0, mem_addr=BASE_ADDR, FIFO empty, pix_valid=0, r/g/b=0, underrun=0.
  - FSM enters IDLE, fetch counter = 0.
- FSM states:
  - IDLE: waits for frame_start, then goes to FETCH.
  - FETCH: issues requests.
  - DONE: all H_ACTIVE*V_ACTIVE words fetched for this frame.
  - DONE -> FETCH on the next frame_start; IDLE -> FETCH on frame_start.
- Request issue:
  - In FETCH, with no request outstanding, and (FIFO count) < FIFO_DEPTH, assert mem_req the next cycle with the current address.
  - At most one request outstanding at a time.
  - mem_req and mem_addr stay constant until the cycle mem_ack=1.
  - mem_req deasserts in the cycle after the ack unless a new request is issued back-to-back. Back-to-back is allowed if the room rule still holds after counting the write.
  - Peak throughput: one word per 2 cycles with a zero-wait memory.
- On mem_ack:
  - Write mem_data[8:0] into the FIFO.
  - Increment mem_addr and the fetch counter.
  - When the counter reaches H_ACTIVE*V_ACTIVE, go to DONE; no further requests.
- FIFO:
  - First-word fall-through: r/g/b show the head entry combinationally from storage; 0 when empty.
  - Write and pop in the same cycle are both honoured, count unchanged.
  - Write into a FIFO that is empty but popped that cycle: the pop is an underrun; the written word becomes the head.
- pix_rd while empty:
  - No pointer change; r/g/b=0 that cycle.
  - underrun<=1, held until the next frame_start or reset.
- frame_start:
  - Flush the FIFO (pointers to 0, count 0); clear underrun.
  - mem_addr<=BASE_ADDR, counter<=0, state<=FETCH.
  - If a request is outstanding, mem_req stays high until its ack. That ack's data is discarded: no FIFO write, no address or counter advance. A drop flag tracks this.
  - The first new request follows the discard.
  - frame_start and mem_ack in the same cycle: treated as frame_start with the in-flight word discarded.
  - A pix_rd in the frame_start cycle is ignored.
- Wrap-around: FIFO pointers wrap modulo FIFO_DEPTH; count is a separate log2(FIFO_DEPTH)+1 bit register.
- Consumer contract:
  - The timing generator pulses frame_start during vertical blanking.
  - It asserts pix_rd once per active pixel.
  - Extra pix_rd after the frame completes just raise underrun.

Decomposition:
- Shared package video_pkg:
  - H_ACTIVE/V_ACTIVE defaults, shared with the timing generator.
  - RGB field bit positions (8:6, 5:3, 2:0).
  - FSM state encoding (IDLE, FETCH, DONE).
- One natural sub-module: video_pixel_fifo.
  - Parameterised FWFT FIFO with count, full, empty and flush.
  - Instantiated once. The fetch FSM, address counter and drop flag live in the top.

Test Plan:
All scenarios use H_ACTIVE=4, V_ACTIVE=2, FIFO_DEPTH=4, BASE_ADDR=0x100. The memory model returns data = addr[8:0] after N wait cycles.
- Reset then idle: rst low 3 cycles, no frame_start for 20 cycles -> mem_req=0, pix_valid=0, r/g/b=0, mem_addr=0x100 throughout.
- Prefetch fill, zero-wait, no pix_rd after frame_start:
  - Exactly 4 requests, addrs 0x100..0x103, then mem_req stays 0.
  - pix_valid=1; head r/g/b = 0x100[8:0] split: r=4, g=0, b=0.
- Full frame, 2-wait memory, pix_rd every 3rd cycle after pix_valid:
  - 8 pixels popped in address order 0x100..0x107.
  - State DONE, underrun=0, no request beyond 0x107.
- Underrun: pix_rd held high continuously from frame_start+1 with 5-wait memory -> underrun=1 within the first pops, r/g/b=0 on empty cycles; next frame_start clears underrun.
- Mid-fetch restart: frame_start while the request for 0x102 is pending (ack 3 cycles later):
  - 0x102 data not written; FIFO empty.
  - Next request addr=0x100 is issued after that ack.
- Async reset mid-frame: rst low between clock edges while mem_req=1 -> mem_req, pix_valid, underrun drop to 0 immediately, before the next edge.
